// File: rtl/alu_driver.sv
// alu_driver: request/response front-end for a combinational alu.
//
// A request (req_a/req_b/req_op) is accepted on req_valid & req_ready in IDLE and driven
// to the alu through registers. After SETTLE_CYCLES cycles the alu result and flag are
// captured and offered on the response port until rsp_valid & rsp_ready.
//
// Ports:
//   clk, reset_n                 clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready          request handshake; req_a, req_b, req_op request payload
//   alu_a, alu_b, alu_op         registered operands/opcode driven to the alu
//   alu_result, alu_flag         combinational alu outputs
//   rsp_valid/rsp_ready          response handshake; rsp_result, rsp_flag, rsp_err payload
//   busy                         high whenever the FSM is not idle
//
// Optional feature macro: ALU_OPCHECK_EN
//   Defined: illegal opcodes bypass the alu and return rsp_err=1 with a zero result.
//   Undefined: every opcode is issued and rsp_err is constant 0.

module alu_driver #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_flag_q, rsp_flag_d;
  logic             rsp_valid_q, rsp_valid_d;

`ifdef ALU_OPCHECK_EN
  logic rsp_err_q, rsp_err_d;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010: op_legal = 1'b1;
      default:                                                       op_legal = 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    rsp_valid_d  = rsp_valid_q;
`ifdef ALU_OPCHECK_EN
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid) begin
`ifdef ALU_OPCHECK_EN
          if (!op_legal(req_op)) begin
            // Rejected op never reaches the alu; alu inputs keep their old values.
            rsp_result_d = '0;
            rsp_flag_d   = 1'b0;
            rsp_err_d    = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = StResp;
          end else begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_op_d = req_op;
            cnt_d    = CntInit;
            state_d  = StSettle;
          end
`else
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          alu_op_d = req_op;
          cnt_d    = CntInit;
          state_d  = StSettle;
`endif
        end
      end
      StSettle: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = alu_result;
          rsp_flag_d   = alu_flag;
`ifdef ALU_OPCHECK_EN
          rsp_err_d    = 1'b0;
`endif
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        // Only rsp_valid clears; result/flag hold until the next capture.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 4'd0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

`ifdef ALU_OPCHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;

endmodule
